load_store_unit: RTL and testbench

- Multi-cycle memory-access stage fed by the ALU result: ALU output is the effective address, rs2 is store data.
- Converts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned, byte-enabled memory transactions.
- Handles a variable-latency memory through a req/ready handshake and stalls the pipeline while the access is in flight.
- Returns sign- or zero-extended load data to writeback, and reports misaligned or illegal accesses without touching memory.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/load_extend.sv | 33 +++
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Holds funct3 and FSM encodings plus the request legality check.
// No state; combinational helpers only.
package lsu_pkg;

  localparam int WORD_OFFSET_BITS = 2;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } lsu_funct3_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // Returns 1 when the request must be rejected without touching memory:
  // an unsupported funct3 for the direction, or a halfword/word access that
  // does not sit on its natural boundary.
  function automatic logic lsu_req_err(input logic                        is_store,
                                       input logic [2:0]                  funct3,
                                       input logic [WORD_OFFSET_BITS-1:0] offset);
    logic illegal;
    logic misaligned;
    if (is_store) begin
      illegal = (funct3 > 3'd2);
    end else begin
      illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    end
    misaligned = ((funct3[1:0] == 2'b01) && offset[0]) ||
                 ((funct3[1:0] == 2'b10) && (offset != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword from a read word and extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_extend
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]       rdata_i,
  input  logic [WORD_OFFSET_BITS-1:0] offset_i,
  input  logic [2:0]                  funct3_i,
  output logic [DATA_WIDTH-1:0]       data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select then sign/zero extension according to funct3.
  always_comb begin
    byte_lane = rdata_i[{offset_i, 3'b000} +: 8];
    half_lane = rdata_i[{offset_i[1], 4'b0000} +: 16];
    data_o    = '0;
    case (funct3_i)
      LB:      data_o = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
      LBU:     data_o = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
      LH:      data_o = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
      LHU:     data_o = {{(DATA_WIDTH-16){1'b0}}, half_lane};
      LW:      data_o = rdata_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store stage: turns LB..SW into word-aligned byte-enabled memory accesses.
// Latency: 2 cycles start->done with zero-wait memory, 1 cycle for rejected requests.
// Backpressure: stalls upstream while memory holds mem_ready_i low; no timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  is_store_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [BE_WIDTH-1:0]   mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  lsu_state_e                  state_q, state_d;
  logic [2:0]                  funct3_q, funct3_d;
  logic [WORD_OFFSET_BITS-1:0] offset_q, offset_d;
  logic                        err_q, err_d;
  logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
  logic                        mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0]       mem_addr_q, mem_addr_d;
  logic [BE_WIDTH-1:0]         mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0]       mem_wdata_q, mem_wdata_d;

  logic                        req_err;
  logic [BE_WIDTH-1:0]         be_calc;
  logic [DATA_WIDTH-1:0]       wdata_calc;
  logic [DATA_WIDTH-1:0]       load_ext;

  load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extend (
    .rdata_i  (mem_rdata_i),
    .offset_i (offset_q),
    .funct3_i (funct3_q),
    .data_o   (load_ext)
  );

  // Request legality plus byte-enable and lane-replicated store data from raw inputs.
  always_comb begin
    req_err    = lsu_req_err(is_store_i, funct3_i, addr_i[WORD_OFFSET_BITS-1:0]);
    be_calc    = '1;
    wdata_calc = wdata_i;
    if (is_store_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          be_calc    = {{(BE_WIDTH-1){1'b0}}, 1'b1} << addr_i[WORD_OFFSET_BITS-1:0];
          wdata_calc = {BE_WIDTH{wdata_i[7:0]}};
        end
        2'b01: begin
          be_calc    = {{(BE_WIDTH-2){1'b0}}, 2'b11} << addr_i[WORD_OFFSET_BITS-1:0];
          wdata_calc = {(BE_WIDTH/2){wdata_i[15:0]}};
        end
        default: begin
          be_calc    = '1;
          wdata_calc = wdata_i;
        end
      endcase
    end
  end

  // FSM next-state, latched request fields and handshake outputs.
  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    offset_d    = offset_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    stall_o     = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state_q)
      IDLE: begin
        stall_o = start_i;
        if (start_i) begin
          funct3_d    = funct3_i;
          offset_d    = addr_i[WORD_OFFSET_BITS-1:0];
          err_d       = req_err;
          mem_we_d    = is_store_i;
          mem_addr_d  = {addr_i[DATA_WIDTH-1:WORD_OFFSET_BITS], {WORD_OFFSET_BITS{1'b0}}};
          mem_be_d    = be_calc;
          mem_wdata_d = wdata_calc;
          if (req_err) begin
            rdata_d = '0;
            state_d = RESP;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        stall_o = 1'b1;
        if (mem_ready_i) begin
          rdata_d = mem_we_q ? '0 : load_ext;
          state_d = RESP;
        end
      end
      RESP: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_o   = (state_q == ACCESS);
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rdata_o     = rdata_q;

  // State and latched-field registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      funct3_q    <= '0;
      offset_q    <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      offset_q    <= offset_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios then randomized transactions.
// Expected results come from a transaction-level model of the RV32I access rules.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .is_store_i  (is_store_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_err(input bit st, input int f3, input int unsigned addr);
    bit legal;
    int unsigned size;
    if (st) legal = (f3 == 0 || f3 == 1 || f3 == 2);
    else    legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    if (!legal) return 1'b1;
    size = 1 << (f3 % 4);
    return (addr % size) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input int f3, input int unsigned addr, input int unsigned word);
    int unsigned off = addr % 4;
    int unsigned b   = (word >> (8 * off)) & 32'hFF;
    int unsigned h   = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      0:       return (b >= 128) ? b + 32'hFFFFFF00 : b;
      4:       return b;
      1:       return (h >= 32768) ? h + 32'hFFFF0000 : h;
      5:       return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input bit st, input int f3, input int unsigned addr);
    if (!st || f3 == 2) return 4'hF;
    if (f3 == 0) return 4'(1 << (addr % 4));
    return 4'(3 << (addr % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input int f3, input int unsigned wd);
    if (f3 == 0) return (wd & 32'hFF) * 32'h01010101;
    if (f3 == 1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  // ---------------- driver/checker ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start_i = 1'b0; is_store_i = 1'b0; funct3_i = 3'd0;
    addr_i = '0; wdata_i = '0; mem_ready_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete transaction. waits = ACCESS cycles with ready low before the
  // ready cycle; poke = also raise start_i during ACCESS and RESP.
  task automatic run_txn(input bit st, input int f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] word,
                         input int waits, input bit poke);
    bit          e_err   = ref_err(st, f3, addr);
    logic [31:0] e_rdata = (st || e_err) ? 32'h0 : ref_load(f3, addr, word);
    @(negedge clk);
    start_i = 1'b1; is_store_i = st; funct3_i = 3'(f3); addr_i = addr; wdata_i = wd;
    mem_ready_i = 1'b0;
    #1;
    chk("idle_stall", {31'b0, stall_o}, 32'd1);
    chk("idle_req", {31'b0, mem_req_o}, 32'd0);
    @(negedge clk);
    start_i = 1'b0;
    if (!e_err) begin
      for (int c = 0; c <= waits; c++) begin
        start_i     = poke && (c == 0);
        is_store_i  = 1'($urandom);
        funct3_i    = 3'($urandom);
        addr_i      = $urandom;
        wdata_i     = $urandom;
        mem_ready_i = (c == waits);
        mem_rdata_i = (c == waits) ? word : $urandom;
        #1;
        chk("acc_req", {31'b0, mem_req_o}, 32'd1);
        chk("acc_stall", {31'b0, stall_o}, 32'd1);
        chk("acc_done", {31'b0, done_o}, 32'd0);
        chk("acc_we", {31'b0, mem_we_o}, {31'b0, st});
        chk("acc_addr", mem_addr_o, addr & 32'hFFFFFFFC);
        chk("acc_be", {28'b0, mem_be_o}, {28'b0, ref_be(st, f3, addr)});
        if (st) chk("acc_wdata", mem_wdata_o, ref_wdata(f3, wd));
        @(negedge clk);
      end
    end
    start_i = poke; mem_ready_i = 1'b0; mem_rdata_i = $urandom;
    #1;
    chk("resp_done", {31'b0, done_o}, 32'd1);
    chk("resp_err", {31'b0, err_o}, {31'b0, e_err});
    chk("resp_rdata", rdata_o, e_rdata);
    chk("resp_stall", {31'b0, stall_o}, 32'd0);
    chk("resp_req", {31'b0, mem_req_o}, 32'd0);
    @(negedge clk);
    start_i = 1'b0;
    #1;
    chk("post_done", {31'b0, done_o}, 32'd0);
    chk("post_err", {31'b0, err_o}, 32'd0);
    chk("post_req", {31'b0, mem_req_o}, 32'd0);
    chk("post_rdata_hold", rdata_o, e_rdata);
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_be", {28'b0, mem_be_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);

    // Directed scenarios
    run_txn(1'b0, 2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);  // LW
    run_txn(1'b0, 0, 32'h103, 32'h0, 32'h80FF0000, 0, 1'b0);  // LB  -> FFFFFF80
    run_txn(1'b0, 4, 32'h103, 32'h0, 32'h80FF0000, 0, 1'b0);  // LBU -> 00000080
    run_txn(1'b1, 1, 32'h202, 32'h1234ABCD, 32'h0, 0, 1'b0);  // SH
    run_txn(1'b0, 2, 32'h101, 32'h0, 32'h0, 0, 1'b0);         // misaligned LW
    run_txn(1'b1, 0, 32'h2F1, 32'h000000A5, 32'h0, 3, 1'b1);  // SB with 3 wait cycles
    run_txn(1'b0, 5, 32'h302, 32'h0, 32'h8001_7FFE, 1, 1'b0); // LHU upper half
    run_txn(1'b0, 1, 32'h302, 32'h0, 32'h8001_7FFE, 0, 1'b0); // LH upper half
    run_txn(1'b0, 3, 32'h400, 32'h0, 32'h0, 0, 1'b0);         // illegal load funct3
    run_txn(1'b1, 4, 32'h400, 32'h0, 32'h0, 0, 1'b0);         // illegal store funct3

    // Reset in the middle of ACCESS
    @(negedge clk);
    start_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'd2; addr_i = 32'h500; mem_ready_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    #1;
    chk("mid_req_before_rst", {31'b0, mem_req_o}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("mid_rst_done", {31'b0, done_o}, 32'd0);
    chk("mid_rst_rdata", rdata_o, 32'd0);
    chk("mid_rst_stall", {31'b0, stall_o}, 32'd0);
    run_txn(1'b0, 2, 32'h504, 32'h0, 32'h13579BDF, 0, 1'b0);

    // Randomized transactions
    for (int i = 0; i < 300; i++) begin
      run_txn(1'($urandom), int'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
